// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences one RV32M multiply through the fixed-latency mul datapath,
// with an optional single-entry product cache that short-circuits MULH*-then-MUL pairs.
module mul_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter bit FUSE_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [4:0]  in_rd_addr,
  input  logic        flush,
  output logic        mul_en,
  output logic [31:0] mul_rs1,
  output logic [31:0] mul_rs2,
  output logic        mul_rs1_signed,
  output logic        mul_rs2_signed,
  input  logic [63:0] mul_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd_addr
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CW = $clog2(MUL_LATENCY + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic hi;
  logic c_valid, c_s1, c_s2;
  logic [31:0] c_rs1, c_rs2;
  logic [63:0] c_prod;
  logic s1, s2, accept, hit;
  assign s1 = in_op != 2'b11;
  assign s2 = !in_op[1];
  assign accept = in_valid && in_ready && !flush;
  // the low half of a product does not depend on operand signedness
  assign hit = FUSE_EN && c_valid && in_rs1 == c_rs1 && in_rs2 == c_rs2 &&
               (in_op == 2'b00 || (s1 == c_s1 && s2 == c_s2));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      mul_en <= 1'b0;
      out_valid <= 1'b0;
      mul_rs1 <= '0;
      mul_rs2 <= '0;
      mul_rs1_signed <= 1'b0;
      mul_rs2_signed <= 1'b0;
      out_data <= '0;
      out_rd_addr <= '0;
      cnt <= '0;
      hi <= 1'b0;
      c_valid <= 1'b0;
      c_s1 <= 1'b0;
      c_s2 <= 1'b0;
      c_rs1 <= '0;
      c_rs2 <= '0;
      c_prod <= '0;
    end else begin
      mul_en <= 1'b0;
      if (flush) c_valid <= 1'b0;
      if (flush && state != IDLE) begin
        state <= IDLE;
        in_ready <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (accept) begin
            in_ready <= 1'b0;
            mul_rs1 <= in_rs1;
            mul_rs2 <= in_rs2;
            mul_rs1_signed <= s1;
            mul_rs2_signed <= s2;
            hi <= in_op != 2'b00;
            out_rd_addr <= in_rd_addr;
            if (hit) begin
              state <= DONE;
              out_valid <= 1'b1;
              out_data <= in_op == 2'b00 ? c_prod[31:0] : c_prod[63:32];
            end else begin
              state <= ISSUE;
              mul_en <= 1'b1;
            end
          end
          ISSUE: begin
            state <= WAIT;
            cnt <= CW'(MUL_LATENCY - 1);
          end
          WAIT: if (cnt == '0) begin
            state <= DONE;
            out_valid <= 1'b1;
            out_data <= hi ? mul_rd[63:32] : mul_rd[31:0];
            c_valid <= 1'b1;
            c_rs1 <= mul_rs1;
            c_rs2 <= mul_rs2;
            c_s1 <= mul_rs1_signed;
            c_s2 <= mul_rs2_signed;
            c_prod <= mul_rd;
          end else cnt <= cnt - 1'b1;
          DONE: if (out_ready) begin
            state <= IDLE;
            in_ready <= 1'b1;
            out_valid <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: drives two controllers (cache on / cache off) against behavioural
// multipliers and checks results, latencies and handshakes against a reference model.
module tb_mul_ctrl;
  localparam int L = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic [1:0] in_op = 0;
  logic [31:0] in_rs1 = 0, in_rs2 = 0;
  logic [4:0] in_rd_addr = 0;
  logic in_ready_f, mul_en_f, s1_f, s2_f, out_valid_f;
  logic [31:0] mul_rs1_f, mul_rs2_f, out_data_f;
  logic [63:0] mul_rd_f, prod_f;
  logic [4:0] out_rd_addr_f;
  logic in_ready_n, mul_en_n, s1_n, s2_n, out_valid_n;
  logic [31:0] mul_rs1_n, mul_rs2_n, out_data_n;
  logic [63:0] mul_rd_n, prod_n;
  logic [4:0] out_rd_addr_n;
  logic [63:0] junk = 0;
  longint cyc = 0, due_f = -1, due_n = -1;
  bit sel = 0;
  int errors = 0, checks = 0;
  logic o_ready, o_en, o_s1, o_s2, o_valid;
  logic [31:0] o_rs1, o_data;
  logic [4:0] o_tag;

  mul_ctrl #(.MUL_LATENCY(L), .FUSE_EN(1)) u_fuse (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_addr(in_rd_addr), .flush(flush),
    .mul_en(mul_en_f), .mul_rs1(mul_rs1_f), .mul_rs2(mul_rs2_f),
    .mul_rs1_signed(s1_f), .mul_rs2_signed(s2_f), .mul_rd(mul_rd_f),
    .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f), .out_rd_addr(out_rd_addr_f));
  mul_ctrl #(.MUL_LATENCY(L), .FUSE_EN(0)) u_nofuse (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_addr(in_rd_addr), .flush(flush),
    .mul_en(mul_en_n), .mul_rs1(mul_rs1_n), .mul_rs2(mul_rs2_n),
    .mul_rs1_signed(s1_n), .mul_rs2_signed(s2_n), .mul_rd(mul_rd_n),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n), .out_rd_addr(out_rd_addr_n));

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    longint x, y;
    x = sa ? longint'($signed(a)) : longint'({32'b0, a});
    y = sb ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(x * y);
  endfunction

  // expected architectural result: MUL low half, MULH s*s, MULHSU s*u, MULHU u*u high half
  function automatic logic [31:0] exp_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = ref_prod(a, b, op != 2'b11, op != 2'b10 && op != 2'b11);
    return op == 2'b00 ? p[31:0] : p[63:32];
  endfunction

  // product appears only in the cycle MUL_LATENCY after the enable cycle; garbage otherwise
  always @(posedge clk) begin
    cyc <= cyc + 1;
    junk <= {$urandom, $urandom};
    if (mul_en_f) begin due_f <= cyc + L; prod_f <= ref_prod(mul_rs1_f, mul_rs2_f, s1_f, s2_f); end
    if (mul_en_n) begin due_n <= cyc + L; prod_n <= ref_prod(mul_rs1_n, mul_rs2_n, s1_n, s2_n); end
  end
  assign mul_rd_f = cyc == due_f ? prod_f : junk;
  assign mul_rd_n = cyc == due_n ? prod_n : ~junk;

  assign o_ready = sel ? in_ready_n : in_ready_f;
  assign o_en = sel ? mul_en_n : mul_en_f;
  assign o_s1 = sel ? s1_n : s1_f;
  assign o_s2 = sel ? s2_n : s2_f;
  assign o_valid = sel ? out_valid_n : out_valid_f;
  assign o_rs1 = sel ? mul_rs1_n : mul_rs1_f;
  assign o_data = sel ? out_data_n : out_data_f;
  assign o_tag = sel ? out_rd_addr_n : out_rd_addr_f;

  // issues one op with out_ready=1; times are counted in cycles after the accept edge
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        output int lat, output int en_cnt, output int en_first,
                        output logic [31:0] data, output logic [4:0] tag, output logic [1:0] sg);
    @(negedge clk);
    in_valid = 1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd_addr = rd; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0; in_op = 2'($urandom); in_rs1 = $urandom; in_rs2 = $urandom; in_rd_addr = 5'($urandom);
    lat = -1; en_cnt = 0; en_first = -1; data = 0; tag = 0; sg = 0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (o_en) begin en_cnt++; if (en_first < 0) en_first = n; sg = {o_s1, o_s2}; end
      if (o_valid) begin lat = n; data = o_data; tag = o_tag; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (in_ready_f !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_f); end
    checks++; if ({mul_en_f, out_valid_f, s1_f, s2_f} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {mul_en_f, out_valid_f, s1_f, s2_f}); end
    checks++; if ({mul_rs1_f, mul_rs2_f} !== 64'h0) begin errors++; $display("FAIL reset_operands: got %h want 0", {mul_rs1_f, mul_rs2_f}); end
    checks++; if ({out_data_f, out_rd_addr_f} !== 37'h0) begin errors++; $display("FAIL reset_out: got %h want 0", {out_data_f, out_rd_addr_f}); end
    checks++; if ({in_ready_n, out_valid_n} !== 2'b10) begin errors++; $display("FAIL reset_nofuse: got %b want 10", {in_ready_n, out_valid_n}); end
    rst_n = 1;
  endtask

  task automatic test_ops();
    logic [1:0] ops [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] av [4] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [1:0] sv [4] = '{2'b11, 2'b11, 2'b00, 2'b10};
    int lat, en, ef;
    logic [31:0] d;
    logic [4:0] t;
    logic [1:0] sg;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], av[i], bv[i], 5'(i + 3), lat, en, ef, d, t, sg);
      checks++; if (d !== ev[i]) begin errors++; $display("FAIL ops_data[%0d]: got %h want %h", i, d, ev[i]); end
      checks++; if (lat != L + 2) begin errors++; $display("FAIL ops_latency[%0d]: got %0d want %0d", i, lat, L + 2); end
      checks++; if (en != 1 || ef != 1) begin errors++; $display("FAIL ops_mul_en[%0d]: got count %0d first %0d want 1/1", i, en, ef); end
      checks++; if (sg !== sv[i]) begin errors++; $display("FAIL ops_signed[%0d]: got %b want %b", i, sg, sv[i]); end
      checks++; if (t !== 5'(i + 3)) begin errors++; $display("FAIL ops_tag[%0d]: got %0d want %0d", i, t, i + 3); end
    end
  endtask

  task automatic test_pair(input bit nofuse);
    int lat, en, ef;
    logic [31:0] d;
    logic [4:0] t;
    logic [1:0] sg;
    repeat (10) @(negedge clk);
    sel = nofuse;
    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, lat, en, ef, d, t, sg);
    checks++; if (d !== 32'hFFFFFFFE || lat != L + 2) begin errors++; $display("FAIL pair_mulhu[%0d]: got %h lat %0d want fffffffe lat %0d", nofuse, d, lat, L + 2); end
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, lat, en, ef, d, t, sg);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pair_mul_data[%0d]: got %h want 00000001", nofuse, d); end
    checks++; if (lat != (nofuse ? L + 2 : 1) || en != (nofuse ? 1 : 0)) begin errors++; $display("FAIL pair_mul_path[%0d]: got lat %0d en %0d want lat %0d en %0d", nofuse, lat, en, nofuse ? L + 2 : 1, nofuse ? 1 : 0); end
    checks++; if (t !== 5'd10) begin errors++; $display("FAIL pair_mul_tag[%0d]: got %0d want 10", nofuse, t); end
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, lat, en, ef, d, t, sg);
    checks++; if (d !== 32'h0 || lat != L + 2 || en != 1) begin errors++; $display("FAIL pair_mulh[%0d]: got %h lat %0d en %0d want 0 lat %0d en 1", nofuse, d, lat, en, L + 2); end
    repeat (10) @(negedge clk);
    sel = 0;
  endtask

  task automatic test_stall();
    logic [31:0] x = 32'h12345678, y = 32'h9ABCDEF0, e;
    bit seen = 0;
    e = exp_result(2'd3, x, y);
    @(negedge clk);
    in_valid = 1; in_op = 2'd3; in_rs1 = x; in_rs2 = y; in_rd_addr = 5'd5; out_ready = 0;
    @(posedge clk);
    #1 in_valid = 0;
    for (int n = 0; n < 20 && !o_valid; n++) @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1 within bound", o_valid); end
    for (int k = 0; k < 10; k++) begin
      checks++; if ({o_valid, o_ready, o_data, o_tag} !== {2'b10, e, 5'd5}) begin errors++; $display("FAIL stall_hold[%0d]: got v%b r%b %h %0d want v1 r0 %h 5", k, o_valid, o_ready, o_data, o_tag, e); end
      in_valid = k[0]; in_op = 2'(k); in_rs1 = $urandom; in_rs2 = $urandom;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if ({o_valid, o_ready} !== 2'b01) begin errors++; $display("FAIL stall_release: got v%b r%b want v0 r1", o_valid, o_ready); end
    repeat (8) begin @(negedge clk); if (o_en || o_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL stall_ignored: got activity 1 want 0"); end
  endtask

  task automatic test_flush();
    logic [31:0] x = 32'h0000BEEF, y = 32'hFFFF1234;
    int lat, en, ef;
    logic [31:0] d;
    logic [4:0] t;
    logic [1:0] sg;
    bit seen = 0;
    run_op(2'd3, x, y, 5'd1, lat, en, ef, d, t, sg);
    @(negedge clk);
    in_valid = 1; in_op = 2'd1; in_rs1 = x; in_rs2 = y; in_rd_addr = 5'd2;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    checks++; if ({o_ready, o_valid} !== 2'b10) begin errors++; $display("FAIL flush_wait_idle: got r%b v%b want r1 v0", o_ready, o_valid); end
    repeat (8) begin @(negedge clk); if (o_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_wait_novalid: got out_valid 1 want 0"); end
    run_op(2'd0, x, y, 5'd3, lat, en, ef, d, t, sg);
    checks++; if (lat != L + 2 || en != 1 || d !== exp_result(2'd0, x, y)) begin errors++; $display("FAIL flush_wait_miss: got lat %0d en %0d %h want lat %0d en 1 %h", lat, en, d, L + 2, exp_result(2'd0, x, y)); end
    @(negedge clk);
    in_valid = 1; in_op = 2'd3; in_rs1 = x; in_rs2 = y; in_rd_addr = 5'd4; out_ready = 0;
    @(posedge clk);
    #1 in_valid = 0;
    for (int n = 0; n < 20 && !o_valid; n++) @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL flush_done_valid: got %b want 1 within bound", o_valid); end
    flush = 1; out_ready = 1;
    @(negedge clk);
    flush = 0;
    checks++; if ({o_ready, o_valid} !== 2'b10) begin errors++; $display("FAIL flush_done_drop: got r%b v%b want r1 v0", o_ready, o_valid); end
    run_op(2'd0, x, y, 5'd6, lat, en, ef, d, t, sg);
    checks++; if (lat != L + 2 || en != 1) begin errors++; $display("FAIL flush_done_miss: got lat %0d en %0d want lat %0d en 1", lat, en, L + 2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] x = 32'hCAFE0001, y = 32'h00000123;
    int lat, en, ef;
    logic [31:0] d;
    logic [4:0] t;
    logic [1:0] sg;
    bit seen = 0;
    @(negedge clk);
    in_valid = 1; in_op = 2'd1; in_rs1 = x; in_rs2 = y; in_rd_addr = 5'd17;
    @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if ({o_ready, o_en, o_valid, o_s1, o_s2} !== 5'b10000) begin errors++; $display("FAIL rstmid_ctrl: got %b want 10000", {o_ready, o_en, o_valid, o_s1, o_s2}); end
    checks++; if ({o_rs1, o_data, o_tag} !== 69'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", {o_rs1, o_data, o_tag}); end
    @(negedge clk);
    rst_n = 1;
    repeat (8) begin @(negedge clk); if (o_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_discard: got out_valid 1 want 0"); end
    run_op(2'd2, y, x, 5'd18, lat, en, ef, d, t, sg);
    checks++; if (lat != L + 2 || d !== exp_result(2'd2, y, x) || t !== 5'd18) begin errors++; $display("FAIL rstmid_after: got lat %0d %h %0d want lat %0d %h 18", lat, d, t, L + 2, exp_result(2'd2, y, x)); end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // reference cache: last multiplier-computed operand pair and signedness
  task automatic test_random();
    bit cv = 0, cs1 = 0, cs2 = 0, hit, ms1, ms2;
    logic [31:0] ca = 0, cb = 0, a = 0, b = 0, d;
    logic [1:0] op;
    logic [4:0] rd, t;
    logic [1:0] sg;
    int lat, en, ef;
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom_range(0, 3));
      rd = 5'($urandom);
      if (k == 0 || $urandom_range(0, 1) == 0) begin a = pick(); b = pick(); end
      ms1 = op != 2'd3;
      ms2 = op == 2'd0 || op == 2'd1;
      hit = cv && a == ca && b == cb && (op == 2'd0 || (ms1 == cs1 && ms2 == cs2));
      run_op(op, a, b, rd, lat, en, ef, d, t, sg);
      checks++; if (d !== exp_result(op, a, b) || t !== rd) begin errors++; $display("FAIL rand_data[%0d]: got %h tag %0d want %h tag %0d", k, d, t, exp_result(op, a, b), rd); end
      checks++; if (lat != (hit ? 1 : L + 2) || en != (hit ? 0 : 1)) begin errors++; $display("FAIL rand_path[%0d]: got lat %0d en %0d want lat %0d en %0d", k, lat, en, hit ? 1 : L + 2, hit ? 0 : 1); end
      if (!hit) begin cv = 1; ca = a; cb = b; cs1 = ms1; cs2 = ms2; end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_pair(0);
    test_pair(1);
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1);
  end
endmodule
